// File: rtl/mem_arbiter_if.sv
// Memory fabric bus between the core ports, the arbiter and the peripheral slaves.
// The arbiter takes the slave view; the core and peripherals together take the master view.
interface mem_arbiter_if;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr,  m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        m0_error, m1_error;

    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        bram_valid, uart_valid, clint_valid;
    logic [31:0] bram_rdata, uart_rdata, clint_rdata;
    logic        bram_ready, uart_ready, clint_ready;

    modport slave (
        input  m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_wstrb, m1_wstrb,
        output m0_rdata, m1_rdata, m0_ready, m1_ready, m0_error, m1_error,
        output s_addr, s_wdata, s_wstrb, bram_valid, uart_valid, clint_valid,
        input  bram_rdata, uart_rdata, clint_rdata, bram_ready, uart_ready, clint_ready
    );

    modport master (
        output m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_wstrb, m1_wstrb,
        input  m0_rdata, m1_rdata, m0_ready, m1_ready, m0_error, m1_error,
        input  s_addr, s_wdata, s_wstrb, bram_valid, uart_valid, clint_valid,
        output bram_rdata, uart_rdata, clint_rdata, bram_ready, uart_ready, clint_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the fetch (m0) and load/store (m1) ports onto BRAM/UART/CLINT,
// one transaction in flight, with error responses for unmapped addresses and slave timeouts.
module mem_arbiter #(
    parameter int unsigned bram_depth      = 12,
    parameter logic [31:0] start_base_addr = 32'h0,
    parameter logic [31:0] uart_base_addr  = 32'h100000,
    parameter logic [31:0] uart_top_addr   = 32'h100004,
    parameter logic [31:0] clint_base_addr = 32'h2000000,
    parameter logic [31:0] clint_top_addr  = 32'h200C000,
    parameter int unsigned timeout_cycles  = 256
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {REG_BRAM, REG_UART, REG_CLINT, REG_NONE} region_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    localparam logic [32:0] BRAM_SIZE  = 33'd4 << bram_depth;
    localparam logic [32:0] UART_SIZE  = {1'b0, uart_top_addr - uart_base_addr};
    localparam logic [32:0] CLINT_SIZE = {1'b0, clint_top_addr - clint_base_addr};
    localparam int          CNT_W      = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

    // Offset-based window test: wraps cleanly and avoids constant comparisons against base 0.
    function automatic logic in_window(input logic [31:0] a, input logic [31:0] base,
                                       input logic [32:0] size);
        return {1'b0, a - base} < size;
    endfunction

    state_t            state;
    region_t           region, region_q;
    logic              last_grant, grant, win;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        valid;
    req_t [1:0]        req;
    req_t              win_req;
    logic              sel_ready;
    logic [31:0]       sel_rdata;

    logic [1:0]        m_ready, m_error;
    logic [1:0][31:0]  m_rdata;
    logic [2:0]        s_valid;  // {clint, uart, bram}
    logic [31:0]       s_addr, s_wdata;
    logic [3:0]        s_wstrb;

    assign valid  = {bus.m1_valid, bus.m0_valid};
    assign req[0] = '{addr: bus.m0_addr, wdata: bus.m0_wdata, wstrb: bus.m0_wstrb};
    assign req[1] = '{addr: bus.m1_addr, wdata: bus.m1_wdata, wstrb: bus.m1_wstrb};

    // A lone requester wins; on a tie the master that did not win last time goes.
    always_comb begin
        win = valid[1];
        if (&valid) win = ~last_grant;
    end

    assign win_req = req[win];

    always_comb begin
        region = REG_NONE;
        if (in_window(win_req.addr, start_base_addr, BRAM_SIZE))
            region = REG_BRAM;
        else if (in_window(win_req.addr, uart_base_addr, UART_SIZE))
            region = REG_UART;
        else if (in_window(win_req.addr, clint_base_addr, CLINT_SIZE))
            region = REG_CLINT;
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        case (region_q)
            REG_BRAM:  begin sel_ready = bus.bram_ready;  sel_rdata = bus.bram_rdata;  end
            REG_UART:  begin sel_ready = bus.uart_ready;  sel_rdata = bus.uart_rdata;  end
            REG_CLINT: begin sel_ready = bus.clint_ready; sel_rdata = bus.clint_rdata; end
            default:   begin sel_ready = 1'b0;            sel_rdata = '0;              end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            region_q   <= REG_NONE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            cnt        <= '0;
            m_ready    <= '0;
            m_error    <= '0;
            m_rdata    <= '0;
            s_valid    <= '0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wstrb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|valid) begin
                        grant      <= win;
                        last_grant <= win;
                        region_q   <= region;
                        if (region == REG_NONE) begin
                            m_ready[win] <= 1'b1;
                            m_error[win] <= 1'b1;
                            m_rdata[win] <= '0;
                            state        <= RESP;
                        end else begin
                            s_addr  <= win_req.addr;
                            s_wdata <= win_req.wdata;
                            s_wstrb <= win_req.wstrb;
                            s_valid <= {region == REG_CLINT, region == REG_UART,
                                        region == REG_BRAM};
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    s_valid <= '0;
                    cnt     <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // Ready wins over timeout if both land on the last allowed cycle.
                    if (sel_ready) begin
                        m_ready[grant] <= 1'b1;
                        m_error[grant] <= 1'b0;
                        m_rdata[grant] <= sel_rdata;
                        state          <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        m_ready[grant] <= 1'b1;
                        m_error[grant] <= 1'b1;
                        m_rdata[grant] <= '0;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    m_ready <= '0;
                    m_error <= '0;
                    m_rdata <= '0;
                    s_addr  <= '0;
                    s_wdata <= '0;
                    s_wstrb <= '0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m0_ready    = m_ready[0];
    assign bus.m1_ready    = m_ready[1];
    assign bus.m0_error    = m_error[0];
    assign bus.m1_error    = m_error[1];
    assign bus.m0_rdata    = m_rdata[0];
    assign bus.m1_rdata    = m_rdata[1];
    assign bus.s_addr      = s_addr;
    assign bus.s_wdata     = s_wdata;
    assign bus.s_wstrb     = s_wstrb;
    assign bus.bram_valid  = s_valid[0];
    assign bus.uart_valid  = s_valid[1];
    assign bus.clint_valid = s_valid[2];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand sequences for
// round-robin, timeout with late ready, and reset during WAIT.
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mem_arbiter_if bus();
    mem_arbiter dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // One record per clock cycle: inputs for the cycle, outputs expected in that cycle.
    typedef struct {
        logic        m0v; logic [31:0] m0a;
        logic        m1v; logic [31:0] m1a; logic [31:0] m1wd; logic [3:0] m1ws;
        logic        br, ur, cr; logic [31:0] rd;
        logic        xbv, xuv, xcv; logic [31:0] xsa; logic [31:0] xsw; logic [3:0] xss;
        logic        xr0, xe0; logic [31:0] xd0;
        logic        xr1, xe1; logic [31:0] xd1;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {m0_ready, m0_error, m1_ready, m1_error, bram_valid, uart_valid, clint_valid}
    function automatic logic [6:0] flags();
        return {bus.m0_ready, bus.m0_error, bus.m1_ready, bus.m1_error,
                bus.bram_valid, bus.uart_valid, bus.clint_valid};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        bus.m0_valid = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_wstrb = 0;
        bus.m1_valid = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_wstrb = 0;
        bus.bram_ready = 0; bus.uart_ready = 0; bus.clint_ready = 0;
        bus.bram_rdata = 0; bus.uart_rdata = 0; bus.clint_rdata = 0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " flags"},   32'(flags()),       32'h0);
        chk({name, " s_addr"},  bus.s_addr,         32'h0);
        chk({name, " s_wdata"}, bus.s_wdata,        32'h0);
        chk({name, " s_wstrb"}, 32'(bus.s_wstrb),   32'h0);
        chk({name, " m0_rdata"}, bus.m0_rdata,      32'h0);
        chk({name, " m1_rdata"}, bus.m1_rdata,      32'h0);
    endtask

    task automatic apply(input vec_t t);
        bus.m0_valid = t.m0v; bus.m0_addr = t.m0a; bus.m0_wdata = 0; bus.m0_wstrb = 0;
        bus.m1_valid = t.m1v; bus.m1_addr = t.m1a; bus.m1_wdata = t.m1wd; bus.m1_wstrb = t.m1ws;
        bus.bram_ready = t.br; bus.uart_ready = t.ur; bus.clint_ready = t.cr;
        bus.bram_rdata = t.rd; bus.uart_rdata = t.rd; bus.clint_rdata = t.rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, n, cv_cnt, bad;
        logic [6:0] exp_flags;

        drive_idle();
        #12;
        chk_all_zero("reset");
        cyc();
        reset = 0;

        //        m0v m0a            m1v m1a            m1wd   m1ws  br ur cr rd            bv uv cv s_addr         s_wdata s_wstrb r0 e0 d0            r1 e1 d1
        // m0 BRAM read, ready in first WAIT cycle
        vt.push_back('{1, 32'h10,       0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{1, 32'h10,       0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h10,      32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{1, 32'h10,       0, 32'h0,       32'h0,  4'h0, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0, 32'h10,      32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h10,      32'h0,  4'h0, 1, 0, 32'hDEADBEEF, 0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        // m1 UART byte write; non-selected readies ignored, uart_ready one cycle late
        vt.push_back('{0, 32'h0,        1, 32'h100000,  32'h41, 4'h1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        1, 32'h100000,  32'h41, 4'h1, 0, 0, 0, 32'h0,        0, 1, 0, 32'h100000,  32'h41, 4'h1, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        1, 32'h100000,  32'h41, 4'h1, 1, 0, 1, 32'h55,       0, 0, 0, 32'h100000,  32'h41, 4'h1, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        1, 32'h100000,  32'h41, 4'h1, 0, 1, 0, 32'h55,       0, 0, 0, 32'h100000,  32'h41, 4'h1, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h100000,  32'h41, 4'h1, 0, 0, 32'h0,        1, 0, 32'h55});
        vt.push_back('{0, 32'h0,        0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        // m0 unmapped read: error response the next cycle, no slave valid
        vt.push_back('{1, 32'h300000,   0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 1, 1, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        // m1 one past BRAM top is unmapped
        vt.push_back('{0, 32'h0,        1, 32'h4000,    32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 0, 0, 32'h0,        1, 1, 32'h0});
        // m0 last BRAM word is mapped
        vt.push_back('{1, 32'h3FFC,     0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{1, 32'h3FFC,     0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h3FFC,    32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{1, 32'h3FFC,     0, 32'h0,       32'h0,  4'h0, 1, 0, 0, 32'h12345678, 0, 0, 0, 32'h3FFC,    32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h3FFC,    32'h0,  4'h0, 1, 0, 32'h12345678, 0, 0, 32'h0});
        // m0 at UART top (exclusive) is unmapped
        vt.push_back('{1, 32'h100004,   0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 1, 1, 32'h0,        0, 0, 32'h0});
        // m1 last CLINT word
        vt.push_back('{0, 32'h0,        1, 32'h200BFFC, 32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        1, 32'h200BFFC, 32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h200BFFC, 32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        1, 32'h200BFFC, 32'h0,  4'h0, 0, 0, 1, 32'hCAFE0001, 0, 0, 0, 32'h200BFFC, 32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});
        vt.push_back('{0, 32'h0,        0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h200BFFC, 32'h0,  4'h0, 0, 0, 32'h0,        1, 0, 32'hCAFE0001});
        vt.push_back('{0, 32'h0,        0, 32'h0,       32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,  4'h0, 0, 0, 32'h0,        0, 0, 32'h0});

        foreach (vt[i]) begin
            apply(vt[i]);
            @(negedge clock);
            chk($sformatf("v%0d flags", i), 32'(flags()),
                32'({vt[i].xr0, vt[i].xe0, vt[i].xr1, vt[i].xe1, vt[i].xbv, vt[i].xuv, vt[i].xcv}));
            chk($sformatf("v%0d s_addr", i),   bus.s_addr,         vt[i].xsa);
            chk($sformatf("v%0d s_wdata", i),  bus.s_wdata,        vt[i].xsw);
            chk($sformatf("v%0d s_wstrb", i),  32'(bus.s_wstrb),   32'(vt[i].xss));
            chk($sformatf("v%0d m0_rdata", i), bus.m0_rdata,       vt[i].xd0);
            chk($sformatf("v%0d m1_rdata", i), bus.m1_rdata,       vt[i].xd1);
            cyc();
        end

        // Both masters hold valid from reset: grants must alternate m0, m1, m0, m1.
        drive_idle();
        reset = 1;
        #1;
        chk_all_zero("rr reset");
        cyc();
        reset = 0;
        bus.m0_valid = 1; bus.m0_addr = 32'h100;
        bus.m1_valid = 1; bus.m1_addr = 32'h200;
        bus.bram_ready = 1; bus.bram_rdata = 32'hA5A50000;
        for (int g = 0; g < 4; g++) begin
            found = 0;
            for (int k = 0; k < 10 && found == 0; k++) begin
                @(negedge clock);
                if (bus.bram_valid) found = 1; else cyc();
            end
            chk($sformatf("rr%0d issue seen", g), 32'(found), 32'd1);
            chk($sformatf("rr%0d s_addr", g), bus.s_addr, (g % 2 == 0) ? 32'h100 : 32'h200);
            cyc();
            found = 0;
            for (int k = 0; k < 10 && found == 0; k++) begin
                @(negedge clock);
                if (bus.m0_ready || bus.m1_ready) found = 1; else cyc();
            end
            chk($sformatf("rr%0d grant", g), 32'({bus.m1_ready, bus.m0_ready}),
                (g % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d rdata", g), (g % 2 == 0) ? bus.m0_rdata : bus.m1_rdata,
                32'hA5A50000);
            cyc();
        end
        drive_idle();
        cyc();
        cyc();

        // m1 CLINT read with no clint_ready: 256 WAIT cycles, then error at t+258.
        bus.m1_valid = 1; bus.m1_addr = 32'h2000000;
        bus.clint_rdata = 32'hFFFFFFFF;
        bus.bram_ready = 1; bus.uart_ready = 1;
        n = 0;
        cv_cnt = 0;
        found = 0;
        while (found == 0 && n <= 400) begin
            @(negedge clock);
            if (bus.clint_valid) cv_cnt++;
            if (bus.m1_ready) found = 1;
            else begin
                n++;
                cyc();
            end
        end
        chk("to latency", 32'(n), 32'd258);
        chk("to clint_valid pulses", 32'(cv_cnt), 32'd1);
        chk("to flags", 32'(flags()), 32'b0011000);
        chk("to m1_rdata", bus.m1_rdata, 32'h0);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k == 0) drive_idle();
            bus.clint_ready = (k == 4);
            @(negedge clock);
            if (flags() != 7'b0) bad++;
        end
        chk("late clint_ready dropped", 32'(bad), 32'd0);
        drive_idle();
        cyc();

        // Reset during WAIT discards the transaction; m0 then wins the first tie.
        bus.m0_valid = 1; bus.m0_addr = 32'h20;
        cyc();
        cyc();
        @(negedge clock);
        chk("rst pre s_addr", bus.s_addr, 32'h20);
        #1;
        reset = 1;
        #1;
        chk_all_zero("rst async");
        bus.m0_valid = 0;
        bus.bram_ready = 1;
        cyc();
        reset = 0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (flags() != 7'b0) bad++;
            cyc();
        end
        chk("rst no response", 32'(bad), 32'd0);
        bus.m0_valid = 1; bus.m0_addr = 32'h40;
        bus.m1_valid = 1; bus.m1_addr = 32'h44;
        bus.bram_rdata = 32'h600D;
        @(negedge clock);
        chk("post t flags", 32'(flags()), 32'h0);
        cyc();
        @(negedge clock);
        exp_flags = 7'b0000100;
        chk("post t+1 flags", 32'(flags()), 32'(exp_flags));
        chk("post t+1 s_addr", bus.s_addr, 32'h40);
        cyc();
        cyc();
        @(negedge clock);
        exp_flags = 7'b1000000;
        chk("post t+3 flags", 32'(flags()), 32'(exp_flags));
        chk("post t+3 m0_rdata", bus.m0_rdata, 32'h600D);
        drive_idle();
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-cycle-issue memory fabric between the instruction-fetch port (m0) and the load/store port (m1).
- Decodes each granted address to the BRAM, UART or CLINT region and returns read data to the winning master.
- Generates error responses for unmapped addresses and for timed-out slaves.
- Sits between the core and the peripheral slaves; exactly one transaction is in flight at a time.

Parameters:
- bram_depth, 12, log2 of BRAM words; BRAM occupies [start_base_addr, start_base_addr + 4*2^bram_depth).
- start_base_addr, 32'h0, BRAM base address.
- uart_base_addr / uart_top_addr, 32'h100000 / 32'h100004, UART window [base, top).
- clint_base_addr / clint_top_addr, 32'h2000000 / 32'h200C000, CLINT window [base, top).
- timeout_cycles, 256, maximum cycles waited for a slave ready before an error response; must be ≥2.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_valid, m1_valid  in  1 each  request; held high until the matching m*_ready pulse
- m0_addr, m1_addr  in  32 each  byte address
- m0_wdata, m1_wdata  in  32 each  write data
- m0_wstrb, m1_wstrb  in  4 each  byte write enables; 0 = read
- m0_rdata, m1_rdata  out  32 each  response data, valid while m*_ready is high
- m0_ready, m1_ready  out  1 each  one-cycle completion pulse
- m0_error, m1_error  out  1 each  qualifies m*_ready: unmapped address or timeout
- s_addr  out  32  shared slave address, registered
- s_wdata  out  32  shared slave write data, registered
- s_wstrb  out  4  shared slave write strobe, registered
- bram_valid, uart_valid, clint_valid  out  1 each  one-cycle slave request pulse
- bram_rdata, uart_rdata, clint_rdata  in  32 each  slave read data
- bram_ready, uart_ready, clint_ready  in  1 each  slave completion, sampled only while that slave is selected

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant = m1 so that m0 wins the first tie; timeout counter 0.
- FSM states:
  - IDLE → ISSUE when any m*_valid is high.
  - ISSUE → WAIT.
  - WAIT → RESP when the selected slave's ready is high, or on timeout.
  - IDLE → RESP directly on an unmapped address.
  - RESP → IDLE.
- Arbitration (IDLE): a single requester wins. When both request, the master not equal to last_grant wins (round-robin). Winner index, addr, wdata, wstrb and region are registered; last_grant is updated.
- Decode: compare against the window bounds. BRAM takes precedence over UART, and UART over CLINT, if windows overlap. Addresses outside all windows are unmapped.
- ISSUE:
  - s_addr, s_wdata and s_wstrb are driven from the latched values and held stable until RESP ends.
  - Exactly one of bram_valid / uart_valid / clint_valid pulses for this single cycle.
- WAIT:
  - The counter increments each cycle.
  - Selected ready = 1: latch the selected rdata, error = 0.
  - Counter reaches timeout_cycles − 1 without ready: rdata = 0, error = 1.
  - Ready from a non-selected slave is ignored.
- RESP: the winner's m*_ready is 1 for exactly one cycle with registered rdata and error. The loser's ready stays 0. Unmapped accesses respond here with rdata 0, error 1.
- Latency: a request sampled in IDLE at cycle t, with slave ready in the first WAIT cycle (t+2), gives m*_ready at t+3. Unmapped: m*_ready at t+1.
- A late slave ready arriving after a timeout, or in IDLE/ISSUE, is dropped.
- A master dropping valid mid-transaction does not abort it; the response is still delivered.
- A master keeping valid high after its ready starts a new arbitration in the following IDLE cycle.
- Reset asserted mid-transaction: immediate return to IDLE and all outputs 0; the transaction is discarded with no ready pulse.

Test Plan:
1. m0 reads 32'h10 while bram_ready returns in the first WAIT cycle with rdata 32'hDEADBEEF → bram_valid pulses once at t+1; m0_ready=1, m0_rdata=32'hDEADBEEF, m0_error=0 at t+3.
2. m0 and m1 both valid from reset, both to BRAM, held continuously → grants alternate m0, m1, m0, m1; neither master is starved.
3. m1 writes 32'h41 with wstrb 4'b0001 to 32'h100000 → uart_valid pulses with s_wdata=32'h41 and s_wstrb=4'b0001; m1_ready follows uart_ready by 1 cycle.
4. m0 reads 32'h300000 (unmapped) → m0_ready=1, m0_error=1, m0_rdata=0 at t+1; no slave valid pulses.
5. m1 reads clint_base_addr with clint_ready never asserted, timeout_cycles=256 → m1_ready=1 and m1_error=1 after 256 WAIT cycles; a clint_ready pulse 5 cycles later produces no response.
6. reset asserted during WAIT → all outputs 0 immediately; after release, a new request is served normally with m0 winning the first tie.
